seg_scan_driver: RTL and testbench

Multiplexed seven-segment display driver for the counter board. Consumes the `seg_clock` scan-rate output of the clock divider, steps through `DIGITS` digit positions, and drives one shared segment bus plus per-digit selects from a BCD value. It captures the displayed value once per scan frame, so a counter changing mid-scan never produces a torn display. Sits between the BCD counter logic and the FPGA display pins.

---
 rtl/seg_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed seven-segment scan driver.
// Frame-coherent BCD snapshot, leading-zero blanking, registered outputs.
module seg_scan_driver #(
  parameter int DIGITS        = 4,
  parameter bit COMMON_ANODE  = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  fast_clock,
  input  logic                  rst,
  input  logic                  seg_clock,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  enable,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic                  frame_start
);

  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic POL = COMMON_ANODE;

  logic                r_seg_q;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_snap;
  logic [DIGITS-1:0]   r_dp_snap;
  logic                r_live;
  logic                r_wrap;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic                r_fs;

  logic                w_tick;
  logic                w_last;
  logic [3:0]          w_dig [DIGITS];
  logic [DIGITS-1:0]   w_nz;
  logic [3:0]          w_cur;
  logic                w_blank;
  logic                w_on;
  logic [DIGITS-1:0]   w_an_ah;
  logic [6:0]          w_seg_ah;
  logic                w_dp_ah;

  function automatic logic [6:0] f_decode(
    input logic [3:0] d
  );
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  assign w_tick = seg_clock & ~r_seg_q;
  assign w_last = (r_idx == LAST);

  // Split the snapshot into digits; w_nz[i] = some digit i..top non-zero
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_dig[i] = r_snap[4*i +: 4];
      acc      = acc | (r_snap[4*i +: 4] != 4'd0);
      w_nz[i]  = acc;
    end
  end

  assign w_cur   = w_dig[r_idx];
  assign w_blank = BLANK_LEADING
                 && (r_idx != '0)
                 && !w_nz[r_idx];
  assign w_on    = r_live & enable;

  // Active-high view of the selected digit, before polarity
  always_comb begin
    w_an_ah  = '0;
    w_seg_ah = 7'h00;
    w_dp_ah  = 1'b0;
    if (w_on) begin
      w_an_ah = DIGITS'(1) << r_idx;
      w_dp_ah = r_dp_snap[r_idx];
      if (!w_blank)
        w_seg_ah = f_decode(w_cur);
    end
  end

  // Scan stage: edge detect, digit index, per-frame snapshot
  always_ff @(posedge fast_clock) begin
    if (rst) begin
      r_seg_q   <= 1'b1;
      r_idx     <= LAST;
      r_snap    <= '0;
      r_dp_snap <= '0;
      r_live    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_seg_q <= seg_clock;
      r_wrap  <= w_tick & w_last;
      if (w_tick) begin
        r_live <= 1'b1;
        if (w_last) begin
          r_idx     <= '0;
          r_snap    <= value;
          r_dp_snap <= dp;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

  // Output stage: registered pins with board polarity applied
  always_ff @(posedge fast_clock) begin
    if (rst) begin
      r_an  <= {DIGITS{POL}};
      r_seg <= {7{POL}};
      r_dp  <= POL;
      r_fs  <= 1'b0;
    end else begin
      r_an  <= w_an_ah ^ {DIGITS{POL}};
      r_seg <= w_seg_ah ^ {7{POL}};
      r_dp  <= w_dp_ah ^ POL;
      r_fs  <= r_wrap;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp_out      = r_dp;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed plus random scan test
// against a digit-position reference model.
module tb_seg_scan_driver;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          seg_clock;
  logic [4*D-1:0] value;
  logic [D-1:0]  dp;
  logic          enable;
  logic [D-1:0]  an;
  logic [6:0]    seg;
  logic          dp_out;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  int          m_pos;
  bit          m_live;
  logic [3:0]  m_snap [D];
  logic [D-1:0] m_dps;

  localparam logic [6:0] SEGTAB [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS(D),
    .COMMON_ANODE(1'b1),
    .BLANK_LEADING(1'b1)
  ) dut (
    .fast_clock(clk),
    .rst(rst),
    .seg_clock(seg_clock),
    .value(value),
    .dp(dp),
    .enable(enable),
    .an(an),
    .seg(seg),
    .dp_out(dp_out),
    .frame_start(frame_start)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit m_on();
    return m_live && (enable === 1'b1);
  endfunction

  function automatic logic [D-1:0] e_an();
    if (!m_on()) return '1;
    return ~(D'(1) << m_pos);
  endfunction

  function automatic logic [6:0] e_seg();
    bit blank;
    logic [3:0] d;
    if (!m_on()) return 7'h7F;
    blank = (m_pos > 0);
    for (int k = m_pos; k < D; k++)
      if (m_snap[k] != 4'd0) blank = 1'b0;
    if (blank) return 7'h7F;
    d = m_snap[m_pos];
    if (d < 10) return ~SEGTAB[d];
    return ~7'h40;
  endfunction

  function automatic logic e_dp();
    if (!m_on()) return 1'b1;
    return ~m_dps[m_pos];
  endfunction

  task automatic m_reset();
    m_pos  = D - 1;
    m_live = 1'b0;
    m_dps  = '0;
    for (int k = 0; k < D; k++) m_snap[k] = 4'd0;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp_out), 32'h1);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  // One seg_clock period: low for lo cycles, then high
  task automatic step(string tag, int lo, int hi);
    bit wrap;
    seg_clock = 1'b0;
    repeat (lo) cyc();
    seg_clock = 1'b1;
    m_pos  = (m_pos + 1) % D;
    m_live = 1'b1;
    wrap   = (m_pos == 0);
    if (wrap) begin
      for (int k = 0; k < D; k++)
        m_snap[k] = value[4*k +: 4];
      m_dps = dp;
    end
    cyc();
    cyc();
    chk({tag, "_an"}, 32'(an), 32'(e_an()));
    chk({tag, "_seg"}, 32'(seg), 32'(e_seg()));
    chk({tag, "_dp"}, 32'(dp_out), 32'(e_dp()));
    chk({tag, "_fs"}, 32'(frame_start), 32'(wrap));
    cyc();
    chk({tag, "_fs_end"}, 32'(frame_start), 32'h0);
    chk({tag, "_hold"}, 32'(an), 32'(e_an()));
    repeat (hi - 1) cyc();
  endtask

  initial begin
    logic [6:0] exp_b [4];
    logic [3:0] exp_a [4];
    exp_b = '{7'h19, 7'h30, 7'h24, 7'h79};
    exp_a = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst       = 1'b1;
    seg_clock = 1'b1;
    value     = '0;
    dp        = '0;
    enable    = 1'b1;
    m_reset();

    // Reset with seg_clock held high
    repeat (3) cyc();
    chk_idle("rst_hold");
    rst = 1'b0;
    repeat (4) cyc();
    chk_idle("rst_rel");

    // Basic scan
    value = 16'h1234;
    dp    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step("basic", 2, 2);
      chk("basic_an_lit", 32'(an), 32'(exp_a[i]));
      chk("basic_seg_lit", 32'(seg), 32'(exp_b[i]));
    end

    // Leading zeros
    value = 16'h0050;
    dp    = 4'b0010;
    step("lz0", 1, 2);
    chk("lz0_lit", 32'(seg), 32'h40);
    step("lz1", 2, 1);
    chk("lz1_lit", 32'(seg), 32'h12);
    chk("lz1_dp", 32'(dp_out), 32'h0);
    step("lz2", 1, 1);
    chk("lz2_lit", 32'(seg), 32'h7F);
    chk("lz2_an", 32'(an), 32'hB);
    step("lz3", 3, 2);
    value = 16'h0000;
    dp    = 4'b0000;
    for (int i = 0; i < 4; i++) step("zero", 1, 2);

    // Frame coherence
    value = 16'h1234;
    step("coh0", 2, 2);
    step("coh1", 2, 2);
    value = 16'h5678;
    step("coh2", 2, 2);
    chk("coh2_lit", 32'(seg), 32'h24);
    step("coh3", 2, 2);
    chk("coh3_lit", 32'(seg), 32'h79);
    for (int i = 0; i < 4; i++) step("coh_nx", 1, 1);

    // Enable off for a frame, then invalid code
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("dark", 2, 2);
      chk("dark_an", 32'(an), 32'hF);
    end
    enable = 1'b1;
    value  = 16'h00A7;
    step("inv0", 2, 2);
    step("inv1", 2, 2);
    chk("inv1_lit", 32'(seg), 32'h3F);
    step("inv2", 2, 2);
    chk("inv2_lit", 32'(seg), 32'h7F);
    step("inv3", 2, 2);

    // Mid-scan reset at idx 2
    value = 16'h9876;
    for (int i = 0; i < 3; i++) step("pre", 2, 2);
    rst = 1'b1;
    cyc();
    chk_idle("mid_rst");
    cyc();
    rst = 1'b0;
    m_reset();
    cyc();
    chk_idle("mid_rel");
    value = 16'h4321;
    step("post", 2, 2);
    chk("post_an", 32'(an), 32'hE);
    chk("post_lit", 32'(seg), 32'h79);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < D; k++)
        value[4*k +: 4] = ($urandom_range(0, 2) == 0)
                        ? 4'd0
                        : 4'($urandom_range(0, 15));
      dp     = D'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      step("rnd",
           int'($urandom_range(1, 3)),
           int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
